// File: rtl/sram_frame_reader_if.sv
// SRAM read port and pixel output stream of the frame reader.
// The reader drives the master side; the SRAM/arbiter and consumer sit on the slave side.
interface sram_frame_reader_if;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned PIX_W  = 16;

  logic              sram_grant;
  logic              sram_rd_req;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [PIX_W-1:0]  sram_data_in;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  modport master (
    input  sram_grant, sram_data_in, pix_ready,
    output sram_rd_req, sram_rd_addr, pix_data, pix_valid, pix_last
  );

  modport slave (
    output sram_grant, sram_data_in, pix_ready,
    input  sram_rd_req, sram_rd_addr, pix_data, pix_valid, pix_last
  );
endinterface

// File: rtl/sram_frame_reader.sv
// Streams one frame out of the SRAM frame buffer in raster order, prefetching
// through a credit-limited FIFO fed by fixed-latency SRAM reads.
module sram_frame_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned STRIDE   = 800,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                CLOCK_100,
  input  logic                Reset_h,
  input  logic                new_frame,
  sram_frame_reader_if.master bus,
  output logic                frame_done,
  output logic                underflow
);
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned X_W    = $clog2(H_ACTIVE);
  localparam int unsigned Y_W    = $clog2(V_ACTIVE);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned POP_W  = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int unsigned IF_W   = $clog2(READ_LAT + 1);
  localparam logic [POP_W-1:0] LAST_POP = POP_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [READ_LAT-1:0] pipe_q, pipe_d;
  logic [PTR_W-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [POP_W-1:0]    pops_q, pops_d;
  logic                done_q, done_d, uf_q, uf_d;
  logic [PIX_W-1:0]    mem [DEPTH];

  logic [IF_W-1:0]     inflight;
  logic                rd_req, accept, push, pop, pix_valid, pix_last;

  // Reads already in the pipe reserve FIFO space so returns always find room.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LAT); i++) inflight = inflight + IF_W'(pipe_q[i]);
  end

  assign rd_req    = (state_q == S_RUN) &&
                     ((SUM_W'(count_q) + SUM_W'(inflight)) < SUM_W'(DEPTH));
  assign accept    = rd_req & bus.sram_grant;
  assign push      = pipe_q[READ_LAT-1];
  assign pix_valid = (count_q != '0);
  assign pop       = pix_valid & bus.pix_ready & ~done_q;
  assign pix_last  = pix_valid & (pops_q == LAST_POP);

  assign bus.sram_rd_req  = rd_req;
  assign bus.sram_rd_addr = ADDR_W'(STRIDE) * ADDR_W'(y_q) + ADDR_W'(x_q);
  assign bus.pix_data     = mem[rd_idx_q];
  assign bus.pix_valid    = pix_valid;
  assign bus.pix_last     = pix_last;
  assign frame_done       = done_q;
  assign underflow        = uf_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    pipe_d   = pipe_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    pops_d   = pops_q;
    done_d   = done_q;
    uf_d     = uf_q;

    pipe_d[0] = accept;
    for (int i = 1; i < int'(READ_LAT); i++) pipe_d[i] = pipe_q[i-1];

    // Final accept parks X/Y so the address holds at the last pixel.
    if (accept) begin
      if (x_q == X_W'(H_ACTIVE - 1)) begin
        if (y_q == Y_W'(V_ACTIVE - 1)) begin
          state_d = S_DONE;
        end else begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
      end
    end

    if (push) wr_idx_d = wr_idx_q + PTR_W'(1);
    if (pop) begin
      rd_idx_d = rd_idx_q + PTR_W'(1);
      pops_d   = pops_q + POP_W'(1);
      if (pix_last) done_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.pix_ready && !pix_valid && (state_q != S_IDLE) && !done_q) uf_d = 1'b1;

    // A new frame discards everything, including reads still in flight.
    if (new_frame) begin
      state_d  = S_RUN;
      x_d      = '0;
      y_d      = '0;
      pipe_d   = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
      pops_d   = '0;
      done_d   = 1'b0;
      uf_d     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_100) begin
    if (Reset_h) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      pipe_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      pops_q   <= '0;
      done_q   <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pipe_q   <= pipe_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      pops_q   <= pops_d;
      done_q   <= done_d;
      uf_q     <= uf_d;
    end
  end

  always_ff @(posedge CLOCK_100) begin
    if (push) mem[wr_idx_q] <= bus.sram_data_in;
  end
endmodule
